// File: rtl/example_pkg.sv
// example_pkg: shared constants, defaults and LED colour type for the LED demo
package example_pkg;

    localparam int   NUM_BTN     = 3;
    localparam logic LED_ON      = 1'b0;
    localparam logic LED_OFF     = 1'b1;
    localparam logic BTN_PRESSED = 1'b0;

    localparam int DEF_CNT_BITS    = 24;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_PWM_DUTY    = 64;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_t;

endpackage

// File: rtl/example_led_main_button_sync.sv
// button_sync: multi-bit flip-flop synchroniser, resets to all-ones (buttons released)
module button_sync
    import example_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int WIDTH       = NUM_BTN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

    // shift raw inputs through the chain; stage 0 is the metastability catcher
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/example_led_main.sv
// example_led_main: buttons to active-low RGB LED with idle red heartbeat; EXAMPLE_PWM_EN adds dimming
module example_led_main
    import example_pkg::*;
#(
    parameter int CNT_BITS    = DEF_CNT_BITS,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int PWM_DUTY    = DEF_PWM_DUTY
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] button_i,
    output logic               red_o,
    output logic               green_o,
    output logic               blue_o
);

    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [NUM_BTN-1:0]  btn_sync, btn_s;
    logic                idle, pwm_gate;
    rgb_t                on, led_q, led_d;

    button_sync #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(NUM_BTN)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (button_i),
        .q_o   (btn_sync)
    );

`ifdef EXAMPLE_PWM_EN
    assign pwm_gate = 32'(cnt_q[7:0]) < PWM_DUTY;
`else
    assign pwm_gate = 1'b1;
`endif

    // decode pressed buttons, idle heartbeat and the next LED drive levels
    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        btn_s   = btn_sync ^ {NUM_BTN{~BTN_PRESSED}};
        idle    = (btn_s == '0);
        on.r    = btn_s[0] | (idle & cnt_q[CNT_BITS-1]);
        on.g    = btn_s[1];
        on.b    = btn_s[2];
        led_d.r = (on.r & pwm_gate) ? LED_ON : LED_OFF;
        led_d.g = (on.g & pwm_gate) ? LED_ON : LED_OFF;
        led_d.b = (on.b & pwm_gate) ? LED_ON : LED_OFF;
    end

    // free-running counter and registered LED pins, all forced off on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            led_q <= '{r: LED_OFF, g: LED_OFF, b: LED_OFF};
        end else begin
            cnt_q <= cnt_d;
            led_q <= led_d;
        end
    end

    assign red_o   = led_q.r;
    assign green_o = led_q.g;
    assign blue_o  = led_q.b;

endmodule

// File: tb/tb_example_led_main.sv
// tb_example_led_main: self-checking bench with vector table, corner sequences and random stimulus
module tb_example_led_main;

`ifdef EXAMPLE_PWM_EN
    localparam int CB = 9;
`else
    localparam int CB = 4;
`endif
    localparam int DUTY = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] button_i = 3'b111;
    logic       red_o, green_o, blue_o;

    int cmp_cnt = 0;
    int bad_cnt = 0;

    example_led_main #(.CNT_BITS(CB), .SYNC_STAGES(2), .PWM_DUTY(DUTY)) dut (
        .clk      (clk),
        .reset    (reset),
        .button_i (button_i),
        .red_o    (red_o),
        .green_o  (green_o),
        .blue_o   (blue_o)
    );

    always #41 clk = ~clk;

    // reference model: edges since reset plus the button value seen at each edge
    int         n;
    logic [2:0] hist[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            n = 0;
            hist.delete();
        end else begin
            n = n + 1;
            hist.push_back(button_i);
        end
    end

    function automatic logic [2:0] model_rgb();
        logic [2:0] b, pr;
        logic       hb, gate, r_on;
        if (n == 0) return 3'b111;
        b    = (n >= 3) ? hist[n-3] : 3'b111;
        pr   = ~b;
        hb   = (((n - 1) >> (CB - 1)) % 2) == 1;
        gate = 1'b1;
`ifdef EXAMPLE_PWM_EN
        gate = ((n - 1) % 256) < DUTY;
`endif
        r_on = pr[0] | ((pr == 3'b000) & hb);
        return {~(r_on & gate), ~(pr[1] & gate), ~(pr[2] & gate)};
    endfunction

    task automatic chk(input string nm, input logic [2:0] exp);
        cmp_cnt++;
        if ({red_o, green_o, blue_o} !== exp) begin
            bad_cnt++;
            $display("FAIL %s at n=%0d: RGB got %b want %b", nm, n, {red_o, green_o, blue_o}, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        cmp_cnt++;
        if (got != exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d want %0d", nm, got, exp);
        end
    endtask

    task automatic tick(input logic [2:0] b);
        button_i = b;
        @(negedge clk);
        chk("model", model_rgb());
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1 chk("reset_hold", 3'b111);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        string      nm;
        logic [2:0] btn;
        logic [2:0] exp;
    } vec_t;

    vec_t vecs[7];
    int   lows;

    initial begin
        vecs[0] = '{"all_pressed", 3'b000, 3'b000};
        vecs[1] = '{"btn_001",     3'b001, 3'b100};
        vecs[2] = '{"btn_010",     3'b010, 3'b010};
        vecs[3] = '{"btn_100",     3'b100, 3'b001};
        vecs[4] = '{"red_only",    3'b110, 3'b011};
        vecs[5] = '{"green_only",  3'b101, 3'b101};
        vecs[6] = '{"blue_only",   3'b011, 3'b110};

        #100;
        chk("reset_init", 3'b111);
        @(negedge clk);
        reset = 1'b0;

        // heartbeat from a fresh reset with no buttons pressed
        for (int i = 1; i <= 17; i++) begin
            tick(3'b111);
`ifndef EXAMPLE_PWM_EN
            if (i == 8)  chk("hb_off_cnt7", 3'b111);
            if (i == 9)  chk("hb_on_cnt8", 3'b011);
            if (i == 16) chk("hb_on_cnt15", 3'b011);
            if (i == 17) chk("hb_off_wrap", 3'b111);
`endif
        end

        // table: each combination held, then compared against a fixed colour
        foreach (vecs[k]) begin
            repeat (4) tick(vecs[k].btn);
`ifndef EXAMPLE_PWM_EN
            chk(vecs[k].nm, vecs[k].exp);
`endif
        end

        // latency: change lands on the third edge, not the second
        repeat (4) tick(3'b000);
        tick(3'b011);
        tick(3'b011);
`ifndef EXAMPLE_PWM_EN
        chk("lat_2edges_old", 3'b000);
`endif
        tick(3'b011);
`ifndef EXAMPLE_PWM_EN
        chk("lat_3edges_new", 3'b110);
`endif

        // asynchronous reset mid-run, checked before any clock edge
        repeat (4) tick(3'b000);
        @(posedge clk);
        #10 reset = 1'b1;
        #1 chk("async_reset", 3'b111);
        @(negedge clk);
        reset = 1'b0;

        // heartbeat suppressed while blue held
        repeat (20) tick(3'b011);

        // single-cycle glitch on green
        do_reset();
        repeat (4) tick(3'b111);
        tick(3'b101);
        lows = 0;
        repeat (8) begin
            tick(3'b111);
            if (green_o == 1'b0) lows++;
        end
`ifndef EXAMPLE_PWM_EN
        chk_int("glitch_green_lows", lows, 1);
`endif

        // randomized bursts against the model
        for (int i = 0; i < 300; i++) begin
            logic [2:0] b;
            b = 3'($urandom_range(0, 7));
            repeat ($urandom_range(1, 4)) tick(b);
        end

`ifdef EXAMPLE_PWM_EN
        do_reset();
        repeat (4) tick(3'b110);
        lows = 0;
        repeat (256) begin
            tick(3'b110);
            if (red_o == 1'b0) lows++;
        end
        chk_int("pwm_red_lows", lows, DUTY);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
        $finish;
    end

endmodule
